qpi_slave_phy: RTL and testbench

- Byte-level QPI front-end inside mlaccel_top, directly downstream of the external QPI host (board MCU or simulation bench).
- Synchronises qpi_csb, qpi_clk and qpi_io[3:0] into the `clock` domain.
- Deserialises host nibbles into a byte stream, with start, stop and first-byte (command) markers, for the command decoder.
- Serialises response bytes from the decoder back onto the bus during read phases.

---
 rtl/qpi_slave_phy.sv | 157 +++++++++++++++
 tb/tb_qpi_slave_phy.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qpi_slave_phy.sv
// qpi_slave_phy: byte-level QPI slave front-end.
// Brings csb/clk/io from the host into the `clock` domain, turns host
// nibbles into a byte stream for the command decoder, and shifts response
// bytes back out during read phases.
module qpi_slave_phy #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       qpi_csb,
  input  logic       qpi_clk,
  input  logic [3:0] qpi_io_di,
  output logic [3:0] qpi_io_do,
  output logic       qpi_io_oe,
  output logic       xfer_start,
  output logic       xfer_stop,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  input  logic       tx_en,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_underrun
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
  localparam logic [0:0] MODE_RX   = 1'b0;
  localparam logic [0:0] MODE_TX   = 1'b1;

  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [3:0]             io_sync [SYNC_STAGES];
  logic                   csb_s, csb_d;
  logic                   clk_s, clk_d;
  logic [3:0]             io_s, io_d;

  logic [0:0] state;
  logic [0:0] mode;
  logic       hi_valid;
  logic       first;
  logic       armed;
  logic [3:0] hi;
  logic [3:0] tx_lo;

  logic       clk_rise, clk_fall, csb_fall;
  logic       in_xfer;
  logic       rx_hi, rx_done, tx_load, tx_lo_out, tx_leave;
  logic [7:0] tx_byte;

  // Input synchronisers plus the one-cycle "_d" delay used for edge detection.
  // Data paths carry no reset; their contents are only used once csb is seen.
  always_ff @(posedge clock) begin
    csb_sync   <= {csb_sync[SYNC_STAGES-2:0], qpi_csb};
    clk_sync   <= {clk_sync[SYNC_STAGES-2:0], qpi_clk};
    io_sync[0] <= qpi_io_di;
    for (int i = 1; i < SYNC_STAGES; i++) io_sync[i] <= io_sync[i-1];
    csb_d <= csb_s;
    clk_d <= clk_s;
    io_d  <= io_s;
  end

  assign csb_s = csb_sync[SYNC_STAGES-1];
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign io_s  = io_sync[SYNC_STAGES-1];

  // io_d is aligned with clk_d, so at an edge it holds the nibble the host
  // launched before that edge. A csb rise overrides any clk edge in the same
  // cycle because in_xfer already drops when csb_s is high.
  assign clk_rise  = clk_s & ~clk_d;
  assign clk_fall  = ~clk_s & clk_d;
  assign csb_fall  = csb_d & ~csb_s;
  assign in_xfer   = (state == ST_ACTIVE) && !csb_s;
  assign tx_load   = in_xfer && clk_fall && tx_en;
  assign tx_leave  = in_xfer && clk_fall && !tx_en && (mode == MODE_TX);
  assign tx_lo_out = in_xfer && clk_rise && (mode == MODE_TX);
  assign rx_hi     = in_xfer && clk_rise && (mode == MODE_RX);
  assign rx_done   = in_xfer && clk_fall && !tx_en && (mode == MODE_RX) && hi_valid;
  assign tx_byte   = tx_valid ? tx_data : IDLE_BYTE;

  // Nibble holding registers (data only, no reset).
  always_ff @(posedge clock) begin
    if (rx_hi)   hi    <= io_d;
    if (tx_load) tx_lo <= tx_byte[3:0];
  end

  // Transfer state machine, RX/TX mode control and registered pad/pulse outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      mode        <= MODE_RX;
      hi_valid    <= 1'b0;
      first       <= 1'b0;
      armed       <= 1'b0;
      qpi_io_oe   <= 1'b0;
      qpi_io_do   <= 4'h0;
      xfer_start  <= 1'b0;
      xfer_stop   <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
      rx_first    <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      xfer_start  <= 1'b0;
      xfer_stop   <= 1'b0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      // A transfer already running when reset released is ignored until
      // csb has been observed high.
      if (csb_s) armed <= 1'b1;

      if (state == ST_IDLE) begin
        if (armed && csb_fall) begin
          state      <= ST_ACTIVE;
          xfer_start <= 1'b1;
          mode       <= MODE_RX;
          hi_valid   <= 1'b0;
          first      <= 1'b1;
        end
      end else if (csb_s) begin
        // End of transfer, possibly mid-byte: partial nibble is dropped.
        state     <= ST_IDLE;
        xfer_stop <= 1'b1;
        qpi_io_oe <= 1'b0;
        mode      <= MODE_RX;
        hi_valid  <= 1'b0;
      end else begin
        if (rx_hi) hi_valid <= 1'b1;
        if (rx_done) begin
          rx_valid <= 1'b1;
          rx_data  <= {hi, io_d};
          rx_first <= first;
          first    <= 1'b0;
          hi_valid <= 1'b0;
        end
        if (tx_load) begin
          mode        <= MODE_TX;
          hi_valid    <= 1'b0;
          qpi_io_oe   <= 1'b1;
          qpi_io_do   <= tx_byte[7:4];
          tx_ready    <= tx_valid;
          tx_underrun <= !tx_valid;
        end
        if (tx_lo_out) qpi_io_do <= tx_lo;
        if (tx_leave) begin
          mode      <= MODE_RX;
          qpi_io_oe <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpi_slave_phy.sv
// tb_qpi_slave_phy: directed bench for qpi_slave_phy with a simple QPI host
// model (half-period of 4 system clocks) and a decoder stand-in.
module tb_qpi_slave_phy;

  localparam int HP = 4;

  logic       clock;
  logic       reset;
  logic       qpi_csb;
  logic       qpi_clk;
  logic [3:0] qpi_io_di;
  logic [3:0] qpi_io_do;
  logic       qpi_io_oe;
  logic       xfer_start, xfer_stop;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_first;
  logic       tx_en, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_underrun;

  qpi_slave_phy #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clock(clock), .reset(reset),
    .qpi_csb(qpi_csb), .qpi_clk(qpi_clk), .qpi_io_di(qpi_io_di),
    .qpi_io_do(qpi_io_do), .qpi_io_oe(qpi_io_oe),
    .xfer_start(xfer_start), .xfer_stop(xfer_stop),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_first(rx_first),
    .tx_en(tx_en), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Event monitor: pulse counters and a log of received bytes {first, data}.
  int         n_start = 0, n_stop = 0, n_ready = 0, n_under = 0;
  int         rx_cnt = 0;
  logic [8:0] rx_log [64];
  always @(negedge clock) begin
    if (xfer_start)  n_start++;
    if (xfer_stop)   n_stop++;
    if (tx_ready)    n_ready++;
    if (tx_underrun) n_under++;
    if (rx_valid) begin
      if (rx_cnt < 64) rx_log[rx_cnt] = {rx_first, rx_data};
      rx_cnt++;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int rx_rd    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_rx(input string name, input logic [7:0] d, input logic f);
    check({name, " present"}, 32'(rx_cnt > rx_rd), 1);
    if (rx_cnt > rx_rd && rx_rd < 64) begin
      check({name, " data"}, 32'(rx_log[rx_rd][7:0]), 32'(d));
      check({name, " first"}, 32'(rx_log[rx_rd][8]), 32'(f));
      rx_rd++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // csb low, then the dummy first falling edge; io changes mid-phase.
  task automatic host_start();
    qpi_csb = 1'b0; tick(HP);
    qpi_clk = 1'b0; tick(2);
  endtask

  // Clock is low here; rise captures the high nibble, fall completes the byte.
  task automatic host_byte(input logic [7:0] b);
    qpi_io_di = b[7:4]; tick(2);
    qpi_clk   = 1'b1;   tick(2);
    qpi_io_di = b[3:0]; tick(2);
    qpi_clk   = 1'b0;   tick(2);
  endtask

  // Rise that precedes the first read falling edge.
  task automatic host_turn();
    tick(2);
    qpi_clk = 1'b1; tick(HP);
  endtask

  task automatic host_read(output logic [7:0] b, output logic oe_seen);
    qpi_clk = 1'b0; tick(HP);
    b[7:4]  = qpi_io_do;
    oe_seen = qpi_io_oe;
    qpi_clk = 1'b1; tick(HP);
    b[3:0]  = qpi_io_do;
  endtask

  task automatic host_end();
    if (qpi_clk == 1'b0) begin
      tick(2);
      qpi_csb = 1'b1; tick(HP);
      qpi_clk = 1'b1; tick(HP);
    end else begin
      qpi_csb = 1'b1; tick(2*HP);
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    logic       exp_first;
  } rx_vec_t;

  rx_vec_t wr_vec [3];
  rx_vec_t ta_vec [4];

  initial begin
    logic [7:0] rb;
    logic       oe_s;
    int s0, p0, r0, u0;

    wr_vec[0] = '{8'h21, 8'h21, 1'b1};
    wr_vec[1] = '{8'hA5, 8'hA5, 1'b0};
    wr_vec[2] = '{8'h3C, 8'h3C, 1'b0};
    ta_vec[0] = '{8'h24, 8'h24, 1'b1};
    ta_vec[1] = '{8'h00, 8'h00, 1'b0};
    ta_vec[2] = '{8'h01, 8'h01, 1'b0};
    ta_vec[3] = '{8'h10, 8'h10, 1'b0};

    reset = 1'b1; qpi_csb = 1'b1; qpi_clk = 1'b1; qpi_io_di = 4'h0;
    tx_en = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick(4);
    check("reset oe", 32'(qpi_io_oe), 0);
    check("reset do", 32'(qpi_io_do), 0);
    check("reset rx_valid", 32'(rx_valid), 0);
    check("reset rx_data", 32'(rx_data), 0);
    check("reset xfer_start", 32'(xfer_start), 0);
    check("reset xfer_stop", 32'(xfer_stop), 0);
    check("reset tx_ready", 32'(tx_ready), 0);
    check("reset tx_underrun", 32'(tx_underrun), 0);
    reset = 1'b0; tick(4);

    // Write transfer, table driven.
    s0 = n_start; p0 = n_stop;
    host_start();
    for (int i = 0; i < 3; i++) host_byte(wr_vec[i].din);
    host_end();
    for (int i = 0; i < 3; i++) expect_rx($sformatf("write byte %0d", i), wr_vec[i].exp_data, wr_vec[i].exp_first);
    check("write xfer_start count", 32'(n_start - s0), 1);
    check("write xfer_stop count", 32'(n_stop - p0), 1);
    check("write no extra rx", 32'(rx_cnt), 32'(rx_rd));

    // Status read: underrun first, then 0x01, 0x00.
    r0 = n_ready; u0 = n_under;
    host_start();
    host_byte(8'h20);
    host_turn();
    tx_en = 1'b1; tx_valid = 1'b0;
    host_read(rb, oe_s);
    check("status byte0", 32'(rb), 'hFF);
    check("status oe", 32'(oe_s), 1);
    tx_valid = 1'b1; tx_data = 8'h01;
    host_read(rb, oe_s);
    check("status byte1", 32'(rb), 'h01);
    tx_data = 8'h00;
    host_read(rb, oe_s);
    check("status byte2", 32'(rb), 'h00);
    tx_valid = 1'b0; tx_en = 1'b0;
    host_end();
    check("status oe after csb", 32'(qpi_io_oe), 0);
    check("status underrun count", 32'(n_under - u0), 1);
    check("status ready count", 32'(n_ready - r0), 2);
    expect_rx("status cmd", 8'h20, 1'b1);
    check("status no rx in tx", 32'(rx_cnt), 32'(rx_rd));

    // Underrun x4, then reset while still in TX.
    r0 = n_ready; u0 = n_under;
    host_start();
    host_byte(8'h20);
    host_turn();
    tx_en = 1'b1; tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_read(rb, oe_s);
      check($sformatf("underrun byte %0d", i), 32'(rb), 'hFF);
    end
    check("underrun count", 32'(n_under - u0), 4);
    check("underrun ready count", 32'(n_ready - r0), 0);
    expect_rx("underrun cmd", 8'h20, 1'b1);
    reset = 1'b1; tick(1);
    check("reset in tx oe", 32'(qpi_io_oe), 0);
    reset = 1'b0; tx_en = 1'b0;
    host_end();

    // Abort mid-byte.
    p0 = n_stop;
    host_start();
    host_byte(8'h23);
    qpi_io_di = 4'h5; tick(2);
    qpi_clk = 1'b1; tick(HP);
    host_end();
    tick(10);
    expect_rx("abort byte", 8'h23, 1'b1);
    check("abort no partial rx", 32'(rx_cnt), 32'(rx_rd));
    check("abort xfer_stop count", 32'(n_stop - p0), 1);

    // Reset during an RX transfer.
    host_start();
    host_byte(8'h31);
    host_byte(8'h32);
    tick(4);
    expect_rx("pre-reset byte0", 8'h31, 1'b1);
    expect_rx("pre-reset byte1", 8'h32, 1'b0);
    s0 = n_start;
    reset = 1'b1; tick(2);
    reset = 1'b0;
    host_byte(8'h33);
    host_byte(8'h34);
    tick(4);
    check("post-reset no rx", 32'(rx_cnt), 32'(rx_rd));
    check("post-reset no start", 32'(n_start - s0), 0);
    host_end();
    host_start();
    host_byte(8'h41);
    host_end();
    expect_rx("new cmd after reset", 8'h41, 1'b1);
    check("new xfer started", 32'(n_start - s0), 1);

    // Turnaround within one transfer.
    r0 = n_ready;
    host_start();
    for (int i = 0; i < 4; i++) host_byte(ta_vec[i].din);
    host_turn();
    tx_en = 1'b1; tx_valid = 1'b1; tx_data = 8'h00;
    check("turn oe before fall", 32'(qpi_io_oe), 0);
    host_read(rb, oe_s);
    check("turn read byte", 32'(rb), 'h00);
    check("turn oe", 32'(oe_s), 1);
    tx_valid = 1'b0; tx_en = 1'b0;
    host_end();
    for (int i = 0; i < 4; i++) expect_rx($sformatf("turn rx %0d", i), ta_vec[i].exp_data, ta_vec[i].exp_first);
    check("turn no extra rx", 32'(rx_cnt), 32'(rx_rd));
    check("turn ready count", 32'(n_ready - r0), 1);
    check("turn oe after csb", 32'(qpi_io_oe), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
